// File: rtl/irig_lock_ctrl.sv
// IRIG-B lock supervisor: tracks frame position, qualifies lock, gates PPS/timestamp strobes.
// Optional free-running holdover PPS after loss of lock is enabled with `define IRIG_HOLDOVER_EN.
module irig_lock_ctrl #(
  parameter int TIMEOUT_CYC    = 1500000,
  parameter int LOCK_FRAMES    = 2,
  parameter int PPS_PERIOD_CYC = 100000000,
  parameter int HOLDOVER_S     = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       irig_d0,
  input  logic       irig_d1,
  input  logic       irig_mark,
  input  logic       pps_gate_in,
  input  logic       ts_finish_in,
  output logic       decoder_rst,
  output logic       locked,
  output logic       pps_out,
  output logic       ts_valid,
  output logic       lock_lost,
  output logic [6:0] frame_pos,
  output logic [7:0] loss_cnt,
  output logic       holdover
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYC);
  localparam logic [3:0]    LOCK_N   = 4'(LOCK_FRAMES);

  if (LOCK_FRAMES < 1 || LOCK_FRAMES > 15 || HOLDOVER_S < 1 || HOLDOVER_S > 255 ||
      TIMEOUT_CYC < 2 || PPS_PERIOD_CYC < 2) begin : g_bad_cfg
    $error("irig_lock_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {ACQUIRE, SYNC, LOCKED} state_t;

  state_t        state;
  logic [TW-1:0] tmo_cnt;
  logic [3:0]    good_cnt;
  logic          prev_mark;
  logic          pps_prev;

  logic       sym;
  logic       data_sym;
  logic       multi;
  logic       mark_pos;
  logic       tmo_hit;
  logic       sym_bad;
  logic       tracking;
  logic       fault;
  logic       accept;
  logic [3:0] good_next;
  logic       enter_lock;
  logic       loss_evt;
  logic       locked_pps;

  assign data_sym   = irig_d0 | irig_d1;
  assign sym        = data_sym | irig_mark;
  assign multi      = (irig_d0 & irig_d1) | (irig_d0 & irig_mark) | (irig_d1 & irig_mark);
  assign mark_pos   = (frame_pos == 7'd0) || ((frame_pos % 7'd10) == 7'd9);
  assign tmo_hit    = !sym && (tmo_cnt == TMO_LAST);
  assign sym_bad    = sym && (multi || (irig_mark && !mark_pos) || (data_sym && mark_pos));
  assign tracking   = (state != ACQUIRE);
  assign fault      = tracking && (sym_bad || tmo_hit);
  assign accept     = tracking && sym && !sym_bad;
  assign good_next  = good_cnt + 4'd1;
  assign enter_lock = accept && (state == SYNC) && (frame_pos == 7'd99) && (good_next == LOCK_N);
  assign loss_evt   = fault && (state == LOCKED);
  assign locked_pps = pps_gate_in && !pps_prev && locked;

  // A fault always wins over a coincident reference marker, but the marker still re-arms prev_mark.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ACQUIRE;
      frame_pos   <= '0;
      good_cnt    <= '0;
      prev_mark   <= 1'b0;
      tmo_cnt     <= '0;
      locked      <= 1'b0;
      decoder_rst <= 1'b0;
      lock_lost   <= 1'b0;
      loss_cnt    <= '0;
      ts_valid    <= 1'b0;
      pps_prev    <= 1'b0;
    end else begin
      decoder_rst <= 1'b0;
      lock_lost   <= 1'b0;
      ts_valid    <= ts_finish_in && locked && !fault;
      pps_prev    <= pps_gate_in;

      if (sym) begin
        tmo_cnt <= '0;
      end else if (tmo_cnt != TMO_MAX) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end

      case (state)
        ACQUIRE: begin
          if (irig_mark && !data_sym) begin
            if (prev_mark) begin
              state     <= SYNC;
              frame_pos <= 7'd1;
              good_cnt  <= '0;
              prev_mark <= 1'b0;
            end else begin
              prev_mark <= 1'b1;
            end
          end else if (data_sym || tmo_hit) begin
            prev_mark <= 1'b0;
          end
        end
        default: begin
          if (fault) begin
            state       <= ACQUIRE;
            frame_pos   <= '0;
            prev_mark   <= irig_mark;
            decoder_rst <= 1'b1;
            locked      <= 1'b0;
            if (state == LOCKED) begin
              lock_lost <= 1'b1;
              if (loss_cnt != 8'hFF) begin
                loss_cnt <= loss_cnt + 8'd1;
              end
            end
          end else if (accept) begin
            frame_pos <= (frame_pos == 7'd99) ? 7'd0 : frame_pos + 7'd1;
            if (state == SYNC && frame_pos == 7'd99) begin
              good_cnt <= good_next;
              if (enter_lock) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

`ifdef IRIG_HOLDOVER_EN
  localparam int HW = $clog2(PPS_PERIOD_CYC);
  localparam logic [HW-1:0] HO_LAST = HW'(PPS_PERIOD_CYC - 1);
  localparam logic [7:0]    HO_N    = 8'(HOLDOVER_S);

  logic [HW-1:0] ho_cnt;
  logic [7:0]    ho_pulses;
  logic          ho_wrap;
  logic          ho_pulse;

  assign ho_wrap  = (ho_cnt == HO_LAST);
  assign ho_pulse = holdover && ho_wrap && !locked_pps;

  // Second counter restarts on every locked PPS so holdover pulses keep the last locked phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ho_cnt    <= '0;
      ho_pulses <= '0;
      holdover  <= 1'b0;
      pps_out   <= 1'b0;
    end else begin
      pps_out <= locked_pps || ho_pulse;
      if (locked_pps || ho_wrap) begin
        ho_cnt <= '0;
      end else begin
        ho_cnt <= ho_cnt + 1'b1;
      end
      if (enter_lock) begin
        holdover <= 1'b0;
      end else if (loss_evt) begin
        holdover  <= 1'b1;
        ho_pulses <= '0;
      end else if (ho_pulse) begin
        ho_pulses <= ho_pulses + 8'd1;
        if (ho_pulses + 8'd1 == HO_N) begin
          holdover <= 1'b0;
        end
      end
    end
  end
`else
  assign holdover = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pps_out <= 1'b0;
    end else begin
      pps_out <= locked_pps;
    end
  end
`endif

endmodule

// File: tb/tb_irig_lock_ctrl.sv
// Self-checking bench for irig_lock_ctrl: scoreboard of expected strobe events plus inline level checks.
module tb_irig_lock_ctrl;

  localparam int TMO = 100;
  localparam int PPS = 1000;
  localparam int HOS = 3;
  localparam int SP  = 10;

  localparam logic [4:0] EV_LR = 5'b10000;
  localparam logic [4:0] EV_DR = 5'b01000;
  localparam logic [4:0] EV_LL = 5'b00100;
  localparam logic [4:0] EV_PP = 5'b00010;
  localparam logic [4:0] EV_TV = 5'b00001;

  logic       clk;
  logic       rst_n;
  logic       irig_d0, irig_d1, irig_mark, pps_gate_in, ts_finish_in;
  logic       decoder_rst, locked, pps_out, ts_valid, lock_lost, holdover;
  logic [6:0] frame_pos;
  logic [7:0] loss_cnt;

  typedef struct {
    int         cyc;
    logic [4:0] ev;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   pos = 0;
  int   last_edge = 0;
  int   pps_edge = 0;
  logic locked_q = 1'b0;
  logic ho_prev = 1'b0;
  logic ho_mask = 1'b1;

  irig_lock_ctrl #(
    .TIMEOUT_CYC(TMO),
    .LOCK_FRAMES(2),
    .PPS_PERIOD_CYC(PPS),
    .HOLDOVER_S(HOS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .irig_d0(irig_d0),
    .irig_d1(irig_d1),
    .irig_mark(irig_mark),
    .pps_gate_in(pps_gate_in),
    .ts_finish_in(ts_finish_in),
    .decoder_rst(decoder_rst),
    .locked(locked),
    .pps_out(pps_out),
    .ts_valid(ts_valid),
    .lock_lost(lock_lost),
    .frame_pos(frame_pos),
    .loss_cnt(loss_cnt),
    .holdover(holdover)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("[TB] FAIL watchdog cyc=%0d limit reached", cyc);
    $fatal(1, "[TB] watchdog");
  end

  // Compare every strobe the DUT produces against the expected-event queue.
  always @(negedge clk) begin : monitor
    logic [4:0] v;
    exp_t       e;
    if (rst_n) begin
      v = {locked && !locked_q, decoder_rst, lock_lost,
           pps_out && !(ho_mask && (holdover || ho_prev)), ts_valid};
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        total++; bad++;
        $display("[TB] FAIL sb_missing cyc=%0d got=none want=%b@%0d", cyc, e.ev, e.cyc);
      end
      if (v != 5'b0) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("[TB] FAIL sb_unexpected cyc=%0d got=%b want=none", cyc, v);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc !== cyc || e.ev !== v) begin
            bad++;
            $display("[TB] FAIL sb_event got=%b@%0d want=%b@%0d", v, cyc, e.ev, e.cyc);
          end
        end
      end
    end
    locked_q = locked;
    ho_prev  = holdover;
  end

  function automatic logic [2:0] good_sym(input int p);
    if (p == 0 || p % 10 == 9) return 3'b100;
    return ($urandom_range(0, 1) == 1) ? 3'b010 : 3'b001;
  endfunction

  task automatic push_exp(input int c, input logic [4:0] ev);
    exp_t e;
    e.cyc = c;
    e.ev  = ev;
    exp_q.push_back(e);
  endtask

  // s = {mark, d1, d0}; one pulse cycle followed by idle so symbols are SP cycles apart.
  task automatic send_sym(input logic [2:0] s, input logic fin, input logic [4:0] ev);
    @(negedge clk);
    {irig_mark, irig_d1, irig_d0} = s;
    ts_finish_in = fin;
    last_edge = cyc + 1;
    if (ev != 5'b0) push_exp(cyc + 1, ev);
    @(negedge clk);
    {irig_mark, irig_d1, irig_d0} = 3'b000;
    ts_finish_in = 1'b0;
    repeat (SP - 2) @(negedge clk);
  endtask

  task automatic advance(input logic fin, input logic [4:0] ev);
    send_sym(good_sym(pos), fin, ev);
    pos = (pos == 99) ? 0 : pos + 1;
  endtask

  task automatic relock();
    while (pos != 0) advance(1'b0, 5'b0);
    for (int f = 0; f < 2; f++)
      for (int p = 0; p < 100; p++)
        advance(1'b0, (f == 1 && p == 99) ? EV_LR : 5'b0);
    total++; if (locked !== 1'b1) begin bad++; $display("[TB] FAIL relock_locked got=%b want=1", locked); end
    total++; if (frame_pos !== 7'd0) begin bad++; $display("[TB] FAIL relock_pos got=%0d want=0", frame_pos); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    {irig_mark, irig_d1, irig_d0} = 3'b000;
    pps_gate_in = 1'b0; ts_finish_in = 1'b0;
    repeat (3) @(negedge clk);
    irig_mark = 1'b1; pps_gate_in = 1'b1; ts_finish_in = 1'b1;
    @(negedge clk);
    total++; if (locked !== 1'b0) begin bad++; $display("[TB] FAIL reset_locked got=%b want=0", locked); end
    total++; if (frame_pos !== 7'd0) begin bad++; $display("[TB] FAIL reset_pos got=%0d want=0", frame_pos); end
    total++; if (loss_cnt !== 8'd0) begin bad++; $display("[TB] FAIL reset_loss got=%0d want=0", loss_cnt); end
    total++; if (decoder_rst !== 1'b0) begin bad++; $display("[TB] FAIL reset_drst got=%b want=0", decoder_rst); end
    total++; if ({pps_out, ts_valid, lock_lost, holdover} !== 4'b0)
      begin bad++; $display("[TB] FAIL reset_strobes got=%b want=0000", {pps_out, ts_valid, lock_lost, holdover}); end
    irig_mark = 1'b0; pps_gate_in = 1'b0; ts_finish_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (decoder_rst !== 1'b0) begin bad++; $display("[TB] FAIL post_reset_drst got=%b want=0", decoder_rst); end
  endtask

  task automatic test_pps_unlocked();
    @(negedge clk); pps_gate_in = 1'b1;
    @(negedge clk);
    total++; if (pps_out !== 1'b0) begin bad++; $display("[TB] FAIL pps_unlocked got=%b want=0", pps_out); end
    @(negedge clk);
    total++; if (pps_out !== 1'b0) begin bad++; $display("[TB] FAIL pps_unlocked2 got=%b want=0", pps_out); end
    pps_gate_in = 1'b0;
  endtask

  task automatic test_acquire_lock();
    pos = 99;
    advance(1'b0, 5'b0);
    advance(1'b0, 5'b0);
    total++; if (frame_pos !== 7'd1) begin bad++; $display("[TB] FAIL ref_pos got=%0d want=1", frame_pos); end
    for (int p = 1; p < 100; p++) advance(1'b0, 5'b0);
    total++; if (locked !== 1'b0) begin bad++; $display("[TB] FAIL frame1_locked got=%b want=0", locked); end
    total++; if (frame_pos !== 7'd0) begin bad++; $display("[TB] FAIL frame1_pos got=%0d want=0", frame_pos); end
    for (int p = 0; p < 99; p++) advance(1'b0, 5'b0);
    total++; if (locked !== 1'b0) begin bad++; $display("[TB] FAIL pre99_locked got=%b want=0", locked); end
    advance(1'b0, EV_LR);
    total++; if (locked !== 1'b1) begin bad++; $display("[TB] FAIL lock_rise got=%b want=1", locked); end
    total++; if (frame_pos !== 7'd0) begin bad++; $display("[TB] FAIL lock_pos got=%0d want=0", frame_pos); end
    advance(1'b0, 5'b0);
    total++; if (frame_pos !== 7'd1) begin bad++; $display("[TB] FAIL next_ref_pos got=%0d want=1", frame_pos); end
  endtask

  task automatic test_pps_locked();
    @(negedge clk);
    pps_gate_in = 1'b1;
    pps_edge = cyc + 1;
    push_exp(pps_edge, EV_PP);
    @(negedge clk);
    total++; if (pps_out !== 1'b1) begin bad++; $display("[TB] FAIL pps_locked got=%b want=1", pps_out); end
    @(negedge clk);
    total++; if (pps_out !== 1'b0) begin bad++; $display("[TB] FAIL pps_width got=%b want=0", pps_out); end
    @(negedge clk);
    pps_gate_in = 1'b0;
  endtask

  task automatic test_ts_valid();
    advance(1'b1, EV_TV);
    @(negedge clk);
    ts_finish_in = 1'b1;
    push_exp(cyc + 1, EV_TV);
    @(negedge clk);
    ts_finish_in = 1'b0;
    total++; if (ts_valid !== 1'b1) begin bad++; $display("[TB] FAIL ts_idle got=%b want=1", ts_valid); end
  endtask

  task automatic test_bad_symbol();
    while (pos != 49) advance(1'b0, 5'b0);
    send_sym(3'b010, 1'b0, EV_DR | EV_LL);
    pos = 50;
    total++; if (locked !== 1'b0) begin bad++; $display("[TB] FAIL bad_locked got=%b want=0", locked); end
    total++; if (loss_cnt !== 8'd1) begin bad++; $display("[TB] FAIL bad_loss got=%0d want=1", loss_cnt); end
    relock();
  endtask

  task automatic test_collision();
    while (pos != 9) advance(1'b0, 5'b0);
    send_sym(3'b110, 1'b1, EV_DR | EV_LL);
    pos = 10;
    total++; if (locked !== 1'b0) begin bad++; $display("[TB] FAIL coll_locked got=%b want=0", locked); end
    total++; if (loss_cnt !== 8'd2) begin bad++; $display("[TB] FAIL coll_loss got=%0d want=2", loss_cnt); end
    relock();
  endtask

  task automatic test_timeout();
    push_exp(last_edge + TMO, EV_DR | EV_LL);
    while (cyc < last_edge + TMO - 1) @(negedge clk);
    total++; if (locked !== 1'b1) begin bad++; $display("[TB] FAIL tmo_early got=%b want=1", locked); end
    @(negedge clk);
    total++; if (locked !== 1'b0) begin bad++; $display("[TB] FAIL tmo_locked got=%b want=0", locked); end
    total++; if (loss_cnt !== 8'd3) begin bad++; $display("[TB] FAIL tmo_loss got=%0d want=3", loss_cnt); end
`ifndef IRIG_HOLDOVER_EN
    pps_gate_in = 1'b1;
    @(negedge clk);
    total++; if (pps_out !== 1'b0) begin bad++; $display("[TB] FAIL pps_after_loss got=%b want=0", pps_out); end
    pps_gate_in = 1'b0;
`endif
    pos = 99;
    relock();
  endtask

`ifdef IRIG_HOLDOVER_EN
  task automatic test_holdover();
    int loss_edge;
    ho_mask = 1'b0;
    @(negedge clk);
    pps_gate_in = 1'b1;
    pps_edge = cyc + 1;
    push_exp(pps_edge, EV_PP);
    @(negedge clk);
    pps_gate_in = 1'b0;
    loss_edge = last_edge + TMO;
    push_exp(loss_edge, EV_DR | EV_LL);
    for (int k = 1; k <= HOS; k++) push_exp(pps_edge + k * PPS, EV_PP);
    while (cyc < loss_edge) @(negedge clk);
    total++; if (holdover !== 1'b1) begin bad++; $display("[TB] FAIL ho_start got=%b want=1", holdover); end
    total++; if (loss_cnt !== 8'd4) begin bad++; $display("[TB] FAIL ho_loss got=%0d want=4", loss_cnt); end
    while (cyc < pps_edge + HOS * PPS - 1) @(negedge clk);
    total++; if (holdover !== 1'b1) begin bad++; $display("[TB] FAIL ho_hold got=%b want=1", holdover); end
    @(negedge clk);
    total++; if (holdover !== 1'b0) begin bad++; $display("[TB] FAIL ho_end got=%b want=0", holdover); end
    repeat (PPS + 10) @(negedge clk);
  endtask
`endif

  task automatic test_drain();
    repeat (5) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL sb_drain got=%0d pending want=0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_pps_unlocked();
    test_acquire_lock();
    test_pps_locked();
    test_ts_valid();
    test_bad_symbol();
    test_collision();
    test_timeout();
`ifdef IRIG_HOLDOVER_EN
    test_holdover();
`endif
    test_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/irig_lock_ctrl.md
Name: irig_lock_ctrl

Overview:
- Supervises the IRIG-B frame decoder.
- Tracks the 100-symbol frame position from the symbol classifier's d0/d1/mark pulses.
- Qualifies lock over whole frames and resets the decoder state machine on any framing fault.
- Gates the decoder's PPS and frame-complete strobes, so downstream logic only sees time from a verified, locked frame stream.

Parameters:
- TIMEOUT_CYC, 1500000, maximum cycles between symbols (15 ms at 100 MHz) before a timeout fault.
- LOCK_FRAMES, 2, consecutive error-free frames required to declare lock (1..15).
- PPS_PERIOD_CYC, 100000000, nominal cycles per second for holdover PPS.
- HOLDOVER_S, 10, maximum holdover PPS pulses after loss of lock (1..255).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- irig_d0  in  1  one-cycle pulse, symbol "0"
- irig_d1  in  1  one-cycle pulse, symbol "1"
- irig_mark  in  1  one-cycle pulse, position marker
- pps_gate_in  in  1  PPS gate from the decoder state machine
- ts_finish_in  in  1  frame-complete strobe from the decoder
- decoder_rst  out  1  active-high synchronous reset to the decoder state machine
- locked  out  1  lock qualified
- pps_out  out  1  one-cycle PPS pulse
- ts_valid  out  1  one-cycle strobe: latched timestamp is trustworthy
- lock_lost  out  1  one-cycle pulse on each loss of lock
- frame_pos  out  7  current frame position, 0..99
- loss_cnt  out  8  loss-of-lock events, saturating at 255
- holdover  out  1  free-running PPS active (only with the optional feature)

Behaviour:
- Reset (rst_n low, asynchronous): all outputs and internal counters 0, state ACQUIRE. decoder_rst is 0 during reset.
- Symbol event: sym = d0|d1|mark. More than one of d0/d1/mark high in the same cycle is a fault (in SYNC/LOCKED).
- Expected mark: frame_pos==0 or frame_pos%10==9. On each sym in SYNC/LOCKED:
  - mark at a non-mark position → fault.
  - d0/d1 at a mark position → fault.
  - Otherwise frame_pos <= (frame_pos==99) ? 0 : frame_pos+1.
- Timeout: cycle counter cleared on each sym. Reaching TIMEOUT_CYC → fault (SYNC/LOCKED), or clears the prev_mark flag (ACQUIRE).
- ACQUIRE:
  - prev_mark set on mark, cleared on d0/d1.
  - A mark while prev_mark=1 is the reference marker: go to SYNC, frame_pos <= 1, good_cnt <= 0.
- SYNC:
  - Accepted sym at frame_pos 99 → good_cnt+1.
  - good_cnt reaching LOCK_FRAMES → LOCKED, locked <= 1 in the same cycle.
  - Fault → ACQUIRE.
- LOCKED:
  - Fault → ACQUIRE, locked <= 0, lock_lost pulse, loss_cnt+1 (saturating).
- decoder_rst:
  - One-cycle pulse, registered, on every transition into ACQUIRE from SYNC/LOCKED.
  - Never asserted by the first ACQUIRE after rst_n release.
- pps_out:
  - Registered rising edge of pps_gate_in while locked: one cycle, latency 1 clk.
  - Edges while not locked are suppressed.
- ts_valid:
  - ts_finish_in while locked and no fault in the same cycle; latency 1 clk.
  - If a fault and ts_finish_in coincide, the fault wins: ts_valid=0 and locked drops.
- Fault and reference-marker detection in the same cycle: the fault is processed and the state goes to ACQUIRE; the marker re-arms prev_mark.
- Timeout counter width: ceil(log2(TIMEOUT_CYC+1)); it saturates and does not wrap.

Optional Feature:
- Macro: IRIG_HOLDOVER_EN.
- With the macro defined:
  - On loss of lock, holdover <= 1 and a free-running counter (0..PPS_PERIOD_CYC-1) runs.
  - The counter is phase-aligned to the last locked pps_out: it is cleared on each locked pps_out.
  - At each wrap, pps_out pulses for one cycle, up to HOLDOVER_S pulses; then holdover <= 0.
  - Re-entering LOCKED clears holdover immediately. Reacquisition proceeds in parallel.
  - Locked PPS edges take priority over holdover pulses in the same cycle.
- Without the macro: the holdover port is tied to 0 and pps_out is silent whenever unlocked.

Test Plan:
- Clean IRIG-B stream from reset, two full frames → decoder_rst never pulses; locked rises on the accepted pos-99 symbol of frame 2; frame_pos=0 at the following reference marker.
- Locked; inject d1 at position 49 (mark expected) → one lock_lost pulse, one decoder_rst pulse, loss_cnt=1, locked=0; relocks after 2 more clean frames.
- Locked; stop symbols for TIMEOUT_CYC cycles → fault at exactly TIMEOUT_CYC cycles after the last symbol; loss_cnt increments.
- pps_gate_in rising while unlocked → pps_out stays 0. While locked → pps_out=1 for exactly 1 cycle, one clk later.
- ts_finish_in coincident with a mark/d1 collision → ts_valid=0, lock_lost=1.
- IRIG_HOLDOVER_EN with PPS_PERIOD_CYC=1000, HOLDOVER_S=3; lose lock after a pps_out → 3 pps_out pulses at +1000/+2000/+3000 cycles; holdover then 0.
